// File: rtl/axi_eth_tx.sv
// Ethernet II transmit framer. Arbitrates between the ARP and IP payload
// streams, prepends the 14-byte Ethernet header, forwards the payload and
// zero-pads short payloads up to the 60-byte minimum frame (FCS added by MAC).

package axi_udp_pkg;
    parameter logic [15:0] ETHERTYPE_ARP = 16'h0806;
    parameter logic [15:0] ETHERTYPE_IP  = 16'h0800;
endpackage

module axi_eth_tx #(
    parameter logic [23:0] MAC_MSB = 24'h010203,
    parameter logic [23:0] MAC_LSB = 24'h040506
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [7:0]  arp_s_axis_tdata,
    input  logic        arp_s_axis_tlast,
    input  logic        arp_s_axis_tvalid,
    output logic        arp_s_axis_tready,
    input  logic [47:0] arp_dst_mac,
    input  logic [7:0]  ip_s_axis_tdata,
    input  logic        ip_s_axis_tlast,
    input  logic        ip_s_axis_tvalid,
    output logic        ip_s_axis_tready,
    input  logic [47:0] ip_dst_mac,
    output logic [7:0]  mac_m_axis_tdata,
    output logic        mac_m_axis_tlast,
    output logic        mac_m_axis_tvalid,
    input  logic        mac_m_axis_tready,
    output logic        tx_busy
);
    import axi_udp_pkg::*;

    localparam logic [6:0] MIN_PAYLOAD = 7'd46;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_PAD} state_t;

    state_t      state_q, state_d;
    logic        last_arp_q, last_arp_d;   // 1: ARP was granted last, 0: IP
    logic        sel_arp_q, sel_arp_d;     // source owning the current frame
    logic [47:0] dst_q, dst_d;
    logic [15:0] etype_q, etype_d;
    logic [3:0]  idx_q, idx_d;
    logic [5:0]  cnt_q, cnt_d;

    logic         grant_arp;
    logic [111:0] hdr_w, hdr_sh;
    logic [7:0]   hdr_byte;
    logic [6:0]   cnt_plus;
    logic [7:0]   src_data;
    logic         src_valid, src_last;

    // Header is shifted so the byte at idx_q sits in the top octet.
    assign hdr_w    = {dst_q, MAC_MSB, MAC_LSB, etype_q};
    assign hdr_sh   = hdr_w << {idx_q, 3'b000};
    assign hdr_byte = hdr_sh[111:104];
    assign cnt_plus = {1'b0, cnt_q} + 7'd1;

    assign src_data  = sel_arp_q ? arp_s_axis_tdata  : ip_s_axis_tdata;
    assign src_valid = sel_arp_q ? arp_s_axis_tvalid : ip_s_axis_tvalid;
    assign src_last  = sel_arp_q ? arp_s_axis_tlast  : ip_s_axis_tlast;

    assign tx_busy = (state_q != S_IDLE);

    // State and frame-context registers.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            last_arp_q <= 1'b0;
            sel_arp_q  <= 1'b0;
            dst_q      <= '0;
            etype_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_arp_q <= last_arp_d;
            sel_arp_q  <= sel_arp_d;
            dst_q      <= dst_d;
            etype_q    <= etype_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic and output muxing.
    always_comb begin
        state_d    = state_q;
        last_arp_d = last_arp_q;
        sel_arp_d  = sel_arp_q;
        dst_d      = dst_q;
        etype_d    = etype_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        grant_arp  = 1'b0;

        mac_m_axis_tdata  = 8'h00;
        mac_m_axis_tlast  = 1'b0;
        mac_m_axis_tvalid = 1'b0;
        arp_s_axis_tready = 1'b0;
        ip_s_axis_tready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arp_s_axis_tvalid || ip_s_axis_tvalid) begin
                    // On a tie, hand the frame to the source not served last.
                    grant_arp  = arp_s_axis_tvalid && (!ip_s_axis_tvalid || !last_arp_q);
                    sel_arp_d  = grant_arp;
                    last_arp_d = grant_arp;
                    dst_d      = grant_arp ? arp_dst_mac : ip_dst_mac;
                    etype_d    = grant_arp ? ETHERTYPE_ARP : ETHERTYPE_IP;
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                mac_m_axis_tvalid = 1'b1;
                mac_m_axis_tdata  = hdr_byte;
                if (mac_m_axis_tready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd13) state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                mac_m_axis_tvalid = src_valid;
                mac_m_axis_tdata  = src_data;
                // tlast is only forwarded once the frame has reached minimum size.
                mac_m_axis_tlast  = src_last && (cnt_plus >= MIN_PAYLOAD);
                arp_s_axis_tready = sel_arp_q  && mac_m_axis_tready;
                ip_s_axis_tready  = !sel_arp_q && mac_m_axis_tready;
                if (src_valid && mac_m_axis_tready) begin
                    cnt_d = (cnt_plus >= MIN_PAYLOAD) ? MIN_PAYLOAD[5:0] : cnt_plus[5:0];
                    if (src_last)
                        state_d = (cnt_plus >= MIN_PAYLOAD) ? S_IDLE : S_PAD;
                end
            end
            S_PAD: begin
                mac_m_axis_tvalid = 1'b1;
                mac_m_axis_tlast  = (cnt_plus == MIN_PAYLOAD);
                if (mac_m_axis_tready) begin
                    cnt_d = cnt_plus[5:0];
                    if (cnt_plus == MIN_PAYLOAD) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
